// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned BCD_ADJ_THRESH = 5;
  localparam int unsigned BCD_ADJ_VAL    = 3;
  localparam int unsigned BCD_DIGIT_W    = 4;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Correct the digit so the following left shift carries into the next digit
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
      digit_o = digit_i + BCD_DIGIT_W'(BCD_ADJ_VAL);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one shift step per clock.
// Optional macro BIN2BCD_OVF_EN enables overflow tracking on the ovf port;
// without it ovf is tied low.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [W-1:0]                  bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          ovf
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(W + 1);
  localparam int unsigned SR_W  = BCD_W + W;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   corr;
  logic [SR_W-1:0]    shifted;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept;
  logic               last_step;

  // Per-digit add-3 correction ahead of the shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .digit_i (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_step = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
  // The top bit of the corrected digits falls off here: that is the mod 10^DIGITS truncation
  assign shifted   = {corr, shift_q} << 1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    shift_d = shift_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    if (accept) begin
      shift_d = bin;
      work_d  = '0;
      cnt_d   = CNT_W'(W);
    end else if (state_q == SHIFT) begin
      shift_d = shifted[W-1:0];
      work_d  = shifted[SR_W-1:W];
      cnt_d   = cnt_q - CNT_W'(1);
    end
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
    bcd_d  = last_step ? work_d : bcd_q;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

`ifdef BIN2BCD_OVF_EN
  logic ovf_acc_q, ovf_acc_d;
  logic ovf_q, ovf_d;

  // Accumulate any bit lost off the top digit; publish it with the result
  always_comb begin
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
    if (accept) begin
      ovf_acc_d = 1'b0;
    end else if (state_q == SHIFT) begin
      ovf_acc_d = ovf_acc_q | corr[BCD_W-1];
    end
    if (last_step) begin
      ovf_d = ovf_acc_d;
    end
  end

  // Overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq (3-digit and 2-digit instances).
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        ovf;

  logic        start2;
  logic [7:0]  bin2;
  logic        busy2;
  logic        done2;
  logic [7:0]  bcd2;
  logic        ovf2;

  int vectors;
  int miscompares;
  int overlap;

  bin2bcd_seq #(.W(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  bin2bcd_seq #(.W(8), .DIGITS(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .bin   (bin2),
    .busy  (busy2),
    .done  (done2),
    .bcd   (bcd2),
    .ovf   (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be high together
  always @(negedge clk) begin
    if ((busy && done) || (busy2 && done2)) overlap++;
  end

  // Downstream 3-digit BCD adder used to consume the converter results
  function automatic logic [11:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    logic [4:0]  s;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = 5'(a[i*4 +: 4]) + 5'(b[i*4 +: 4]) + 5'(c);
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[i*4 +: 4] = s[3:0];
    end
    return r;
  endfunction

  // Start one conversion on dut and wait for done
  task automatic run_conv(input logic [7:0] v, output logic [11:0] res,
                          output logic res_ovf, output int lat, output int bcnt);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = 8'hxx;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    res     = bcd;
    res_ovf = ovf;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    bin    = 8'd0;
    start2 = 1'b0;
    bin2   = 8'd0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, bcd, ovf} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_dut3: got busy=%b done=%b bcd=%h ovf=%b, want all 0", busy, done, bcd, ovf);
    end
    vectors++;
    if ({busy2, done2, bcd2, ovf2} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_dut2: got busy=%b done=%b bcd=%h ovf=%b, want all 0", busy2, done2, bcd2, ovf2);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_zero();
    logic [11:0] r;
    logic        o;
    int          lat, bcnt;
    run_conv(8'd0, r, o, lat, bcnt);
    vectors++;
    if (lat !== 8) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d cycles, want 8", lat);
    end
    vectors++;
    if (bcnt !== 8) begin
      miscompares++;
      $display("FAIL zero_busy_cycles: got %0d, want 8", bcnt);
    end
    vectors++;
    if (r !== 12'h000 || o !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_result: got bcd=%h ovf=%b, want 000 0", r, o);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done_pulse: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_values();
    logic [11:0] r255, r99, r100, r9;
    logic        o;
    int          lat, bcnt;
    run_conv(8'd255, r255, o, lat, bcnt);
    vectors++;
    if (r255 !== 12'h255 || o !== 1'b0 || lat !== 8) begin
      miscompares++;
      $display("FAIL conv_255: got bcd=%h ovf=%b lat=%0d, want 255 0 8", r255, o, lat);
    end
    run_conv(8'd99, r99, o, lat, bcnt);
    vectors++;
    if (r99 !== 12'h099 || o !== 1'b0) begin
      miscompares++;
      $display("FAIL conv_99: got bcd=%h ovf=%b, want 099 0", r99, o);
    end
    vectors++;
    if (bcd_add(r255, r99) !== 12'h354) begin
      miscompares++;
      $display("FAIL adder_255_99: got %h, want 354", bcd_add(r255, r99));
    end
    run_conv(8'd100, r100, o, lat, bcnt);
    vectors++;
    if (r100 !== 12'h100) begin
      miscompares++;
      $display("FAIL conv_100: got %h, want 100", r100);
    end
    run_conv(8'd9, r9, o, lat, bcnt);
    vectors++;
    if (r9 !== 12'h009) begin
      miscompares++;
      $display("FAIL conv_9: got %h, want 009", r9);
    end
    vectors++;
    if (bcd_add(r100, r9) !== 12'h109) begin
      miscompares++;
      $display("FAIL adder_100_9: got %h, want 109", bcd_add(r100, r9));
    end
  endtask

  task automatic test_ignore_start();
    int          ndone;
    logic [11:0] cap;
    @(negedge clk);
    bin   = 8'd123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    bin   = 8'd45;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    cap   = 12'hfff;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++;
        cap = bcd;
      end
      @(negedge clk);
    end
    vectors++;
    if (ndone !== 1) begin
      miscompares++;
      $display("FAIL ignore_done_count: got %0d pulses, want 1", ndone);
    end
    vectors++;
    if (cap !== 12'h123 || bcd !== 12'h123) begin
      miscompares++;
      $display("FAIL ignore_result: got %h (held %h), want 123", cap, bcd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vals [2];
    logic [11:0] exp  [2];
    int          n;
    vals[0] = 8'd10;  exp[0] = 12'h010;
    vals[1] = 8'd7;   exp[1] = 12'h007;
    @(negedge clk);
    bin   = vals[0];
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 40);
      vectors++;
      if (n !== 9 || bcd !== exp[i % 2]) begin
        miscompares++;
        $display("FAIL b2b_%0d: got gap=%0d bcd=%h, want gap=9 bcd=%h", i, n, bcd, exp[i % 2]);
      end
      bin = vals[(i + 1) % 2];
      if (i == 3) start = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    int ndone;
    @(negedge clk);
    bin   = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy_before: got busy=%b, want 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_clear: got busy=%b done=%b bcd=%h ovf=%b, want 0 0 000 0", busy, done, bcd, ovf);
    end
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    vectors++;
    if (ndone !== 0) begin
      miscompares++;
      $display("FAIL abort_no_resume: got %0d busy/done cycles, want 0", ndone);
    end
  endtask

  task automatic test_two_digit();
    logic [7:0] vals [2];
    logic [7:0] exp  [2];
    logic       eovf [2];
    int         n;
    vals[0] = 8'd255; exp[0] = 8'h55;
    vals[1] = 8'd99;  exp[1] = 8'h99;
`ifdef BIN2BCD_OVF_EN
    eovf[0] = 1'b1;
`else
    eovf[0] = 1'b0;
`endif
    eovf[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bin2   = vals[i];
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 40) begin
        @(negedge clk);
        n++;
      end
      vectors++;
      if (n !== 8 || bcd2 !== exp[i] || ovf2 !== eovf[i]) begin
        miscompares++;
        $display("FAIL two_digit_%0d: got lat=%0d bcd=%h ovf=%b, want lat=8 bcd=%h ovf=%b",
                 vals[i], n, bcd2, ovf2, exp[i], eovf[i]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    overlap     = 0;
    test_reset();
    test_zero();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_two_digit();
    vectors++;
    if (overlap !== 0) begin
      miscompares++;
      $display("FAIL busy_done_overlap: got %0d cycles, want 0", overlap);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
